// File: rtl/alu_mc.sv
// Multi-cycle ALU with a valid/ready handshake on both sides.
// Shifts move one bit per cycle and MUL is an iterative shift-add; every other opcode completes in one cycle.
module alu_mc #(
    parameter int WIDTH     = 16,
    parameter int IMM_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [3:0]           opcode,
    input  logic                 opcode_mode,
    input  logic [IMM_WIDTH-1:0] immediate,
    input  logic [WIDTH-1:0]     pc,
    input  logic [WIDTH-1:0]     rA,
    input  logic [WIDTH-1:0]     rB,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out,
    output logic                 write_rD,
    output logic                 write_pc,
    output logic [1:0]           memory_mode,
    output logic [3:0]           flags
);
    localparam int SW = $clog2(WIDTH);
    localparam int CW = SW + 1;

    localparam logic [3:0] OP_ADD   = 4'h0;
    localparam logic [3:0] OP_SUB   = 4'h1;
    localparam logic [3:0] OP_OR    = 4'h2;
    localparam logic [3:0] OP_AND   = 4'h3;
    localparam logic [3:0] OP_XOR   = 4'h4;
    localparam logic [3:0] OP_NOT   = 4'h5;
    localparam logic [3:0] OP_READ  = 4'h6;
    localparam logic [3:0] OP_WRITE = 4'h7;
    localparam logic [3:0] OP_LOAD  = 4'h8;
    localparam logic [3:0] OP_CMP   = 4'h9;
    localparam logic [3:0] OP_SHL   = 4'hA;
    localparam logic [3:0] OP_SHR   = 4'hB;
    localparam logic [3:0] OP_JMP   = 4'hC;
    localparam logic [3:0] OP_JMPC  = 4'hD;
    localparam logic [3:0] OP_MUL   = 4'hE;
    localparam logic [3:0] OP_NOP   = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    state_t            state_r;
    logic [WIDTH-1:0]  acc_r;
    logic [WIDTH-1:0]  mcand_r;
    logic [WIDTH-1:0]  mplier_r;
    logic [CW-1:0]     cnt_r;
    logic [3:0]        op_r;
    logic              mode_r;
    logic              in_ready_r;
    logic              out_valid_r;
    logic [WIDTH-1:0]  out_r;
    logic              write_rd_r;
    logic              write_pc_r;
    logic [1:0]        memory_mode_r;
    logic [3:0]        flags_r;

    logic [WIDTH:0]    add_s;
    logic [WIDTH:0]    sub_s;
    logic [WIDTH-1:0]  imm_ext_s;
    logic [WIDTH-1:0]  res_s;
    logic [3:0]        res_flags_s;
    logic              upd_flags_s;
    logic              multi_s;
    logic              wr_rd_s;
    logic              wr_pc_s;
    logic [1:0]        mem_s;
    logic [SW-1:0]     k_s;
    logic [WIDTH-1:0]  step_s;

    // Signed overflow for a +/- b given the result sign; b_sign is already inverted for subtraction.
    function automatic logic ovf(input logic a_sign, input logic b_sign, input logic r_sign);
        return (a_sign == b_sign) && (r_sign != a_sign);
    endfunction

    assign in_ready    = in_ready_r;
    assign out_valid   = out_valid_r;
    assign out         = out_r;
    assign write_rD    = write_rd_r;
    assign write_pc    = write_pc_r;
    assign memory_mode = memory_mode_r;
    assign flags       = flags_r;

    // Single-cycle result, qualifiers and flags computed from the presented operands.
    always_comb begin
        add_s       = {1'b0, rA} + {1'b0, rB};
        sub_s       = {1'b0, rA} - {1'b0, rB};
        imm_ext_s   = opcode_mode ? WIDTH'(immediate) : WIDTH'($signed(immediate));
        k_s         = rB[SW-1:0];
        res_s       = {WIDTH{1'b0}};
        res_flags_s = 4'b0000;
        upd_flags_s = 1'b0;
        multi_s     = 1'b0;
        wr_rd_s     = 1'b1;
        wr_pc_s     = 1'b0;
        mem_s       = 2'b00;
        case (opcode)
            OP_ADD: begin
                res_s       = add_s[WIDTH-1:0];
                upd_flags_s = 1'b1;
                res_flags_s = {add_s[WIDTH-1], (add_s[WIDTH-1:0] == {WIDTH{1'b0}}), add_s[WIDTH],
                               ovf(rA[WIDTH-1], rB[WIDTH-1], add_s[WIDTH-1])};
            end
            OP_SUB, OP_CMP: begin
                upd_flags_s = 1'b1;
                res_flags_s = {sub_s[WIDTH-1], (sub_s[WIDTH-1:0] == {WIDTH{1'b0}}), ~sub_s[WIDTH],
                               ovf(rA[WIDTH-1], ~rB[WIDTH-1], sub_s[WIDTH-1])};
                if (opcode == OP_SUB) begin
                    res_s = sub_s[WIDTH-1:0];
                end else if (opcode_mode ? (rA > rB) : ($signed(rA) > $signed(rB))) begin
                    res_s = {WIDTH{1'b1}};
                end else if (rA != rB) begin
                    res_s = {{(WIDTH-1){1'b0}}, 1'b1};
                end else begin
                    res_s = {WIDTH{1'b0}};
                end
            end
            OP_OR:    res_s = rA | rB;
            OP_AND:   res_s = rA & rB;
            OP_XOR:   res_s = rA ^ rB;
            OP_NOT:   res_s = ~rA;
            OP_READ: begin
                res_s = rA;
                mem_s = 2'b01;
            end
            OP_WRITE: begin
                res_s   = rA;
                mem_s   = 2'b10;
                wr_rd_s = 1'b0;
            end
            OP_LOAD:  res_s = opcode_mode ? WIDTH'(immediate) : (WIDTH'(immediate) << (WIDTH - IMM_WIDTH));
            OP_SHL, OP_SHR: begin
                res_s   = rA;
                multi_s = (k_s != {SW{1'b0}});
            end
            OP_JMP, OP_JMPC: begin
                res_s   = pc + imm_ext_s;
                wr_rd_s = 1'b0;
                wr_pc_s = (opcode == OP_JMP) ? 1'b1 : (rA == rB);
            end
            OP_MUL:   multi_s = 1'b1;
            OP_NOP:   wr_rd_s = 1'b0;
            default: begin
                res_s   = {WIDTH{1'b0}};
                wr_rd_s = 1'b0;
            end
        endcase
    end

    // One iteration of the multi-cycle datapath: a single-bit shift or one shift-add step.
    always_comb begin
        step_s = acc_r;
        case (op_r)
            OP_SHL:  step_s = acc_r << 1;
            OP_SHR:  step_s = mode_r ? (acc_r >> 1) : {acc_r[WIDTH-1], acc_r[WIDTH-1:1]};
            OP_MUL:  step_s = mplier_r[0] ? (acc_r + mcand_r) : acc_r;
            default: step_s = acc_r;
        endcase
    end

    // Control FSM with registered handshake, result, qualifiers and status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= ST_IDLE;
            acc_r         <= {WIDTH{1'b0}};
            mcand_r       <= {WIDTH{1'b0}};
            mplier_r      <= {WIDTH{1'b0}};
            cnt_r         <= {CW{1'b0}};
            op_r          <= 4'h0;
            mode_r        <= 1'b0;
            in_ready_r    <= 1'b1;
            out_valid_r   <= 1'b0;
            out_r         <= {WIDTH{1'b0}};
            write_rd_r    <= 1'b0;
            write_pc_r    <= 1'b0;
            memory_mode_r <= 2'b00;
            flags_r       <= 4'b0000;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (in_valid) begin
                        op_r          <= opcode;
                        mode_r        <= opcode_mode;
                        write_rd_r    <= wr_rd_s;
                        write_pc_r    <= wr_pc_s;
                        memory_mode_r <= mem_s;
                        in_ready_r    <= 1'b0;
                        if (multi_s) begin
                            state_r  <= ST_BUSY;
                            acc_r    <= (opcode == OP_MUL) ? {WIDTH{1'b0}} : rA;
                            mcand_r  <= rA;
                            mplier_r <= rB;
                            cnt_r    <= (opcode == OP_MUL) ? CW'(WIDTH) : CW'(k_s);
                        end else begin
                            state_r     <= ST_DONE;
                            out_r       <= res_s;
                            out_valid_r <= 1'b1;
                            if (upd_flags_s) begin
                                flags_r <= res_flags_s;
                            end
                        end
                    end
                end
                ST_BUSY: begin
                    acc_r    <= step_s;
                    mcand_r  <= mcand_r << 1;
                    mplier_r <= mplier_r >> 1;
                    cnt_r    <= cnt_r - CW'(1);
                    if (cnt_r == CW'(1)) begin
                        state_r     <= ST_DONE;
                        out_r       <= step_s;
                        out_valid_r <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_r     <= ST_IDLE;
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    out_valid_r <= 1'b0;
                    in_ready_r  <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_alu_mc.sv
// Scoreboard bench for alu_mc: a driver pushes model predictions, a monitor pops and compares on out_valid.
module tb_alu_mc;
    localparam int     W    = 16;
    localparam int     IW   = 8;
    localparam longint MASK = 64'hFFFF;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [3:0]    opcode;
    logic          opcode_mode;
    logic [IW-1:0] immediate;
    logic [W-1:0]  pc, ra, rb;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [W-1:0]  out;
    logic          write_rd, write_pc;
    logic [1:0]    memory_mode;
    logic [3:0]    flags;

    typedef struct {
        longint   res;
        logic [3:0] fl;
        logic     wrd;
        logic     wpc;
        logic [1:0] mem;
        int       lat;
        int       acc_cyc;
    } exp_t;

    exp_t        sb_q[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    int          cyc      = 0;
    logic [3:0]  mflags   = 4'b0000;
    int          hold_cycles = 0;
    bit          rnd_ready   = 1'b0;

    alu_mc #(.WIDTH(W), .IMM_WIDTH(IW)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .opcode_mode(opcode_mode), .immediate(immediate),
        .pc(pc), .rA(ra), .rB(rb), .out_valid(out_valid), .out_ready(out_ready),
        .out(out), .write_rD(write_rd), .write_pc(write_pc),
        .memory_mode(memory_mode), .flags(flags)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint req);
        n_checks++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    endtask

    function automatic longint sx(input longint v);
        return (v >= 64'sd32768) ? v - 64'sd65536 : v;
    endfunction

    // Reference model: plain integer arithmetic on the architectural rules.
    task automatic model(input logic [3:0] op, input logic mode, input longint imm,
                         input longint pcv, input longint a, input longint b, output exp_t e);
        longint s, sr, simm;
        bit     upd, c, v;
        int     k;
        e.res = 0; e.wrd = 1'b1; e.wpc = 1'b0; e.mem = 2'b00; e.lat = 1; e.acc_cyc = 0;
        upd = 1'b0; c = 1'b0; v = 1'b0;
        k = int'(b % 16);
        simm = mode ? imm : ((imm >= 128) ? imm - 256 : imm);
        case (op)
            4'h0: begin s = a + b; e.res = s & MASK; c = (s > MASK); sr = sx(a) + sx(b);
                        v = (sr > 32767) || (sr < -32768); upd = 1'b1; end
            4'h1, 4'h9: begin s = a - b; c = (a >= b); sr = sx(a) - sx(b);
                        v = (sr > 32767) || (sr < -32768); upd = 1'b1;
                        if (op == 4'h1) e.res = s & MASK;
                        else if (mode ? (a > b) : (sx(a) > sx(b))) e.res = MASK;
                        else if (a != b) e.res = 1;
                        else e.res = 0;
                        if (op == 4'h9) s = s & MASK; end
            4'h2: e.res = a | b;
            4'h3: e.res = a & b;
            4'h4: e.res = a ^ b;
            4'h5: e.res = (~a) & MASK;
            4'h6: begin e.res = a; e.mem = 2'b01; end
            4'h7: begin e.res = a; e.mem = 2'b10; e.wrd = 1'b0; end
            4'h8: e.res = mode ? imm : (imm << 8);
            4'hA: begin e.res = (a << k) & MASK; e.lat = k + 1; end
            4'hB: begin e.res = mode ? (a >> k) : ((sx(a) >>> k) & MASK); e.lat = k + 1; end
            4'hC: begin e.res = (pcv + simm) & MASK; e.wrd = 1'b0; e.wpc = 1'b1; end
            4'hD: begin e.res = (pcv + simm) & MASK; e.wrd = 1'b0; e.wpc = (a == b); end
            4'hE: begin e.res = (a * b) & MASK; e.lat = W + 1; end
            default: begin e.res = 0; e.wrd = 1'b0; end
        endcase
        if (upd) begin
            s = (op == 4'h0) ? e.res : ((a - b) & MASK);
            mflags = {s[15], (s == 0), c, v};
        end
        e.fl = mflags;
    endtask

    task automatic issue(input logic [3:0] op, input logic mode, input longint imm,
                         input longint pcv, input longint a, input longint b);
        exp_t e;
        int   t;
        t = 0;
        @(negedge clk);
        while (!in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            check("ready_timeout", 0, 1);
            return;
        end
        opcode = op; opcode_mode = mode; immediate = IW'(imm);
        pc = W'(pcv); ra = W'(a); rb = W'(b); in_valid = 1'b1;
        model(op, mode, imm, pcv, a, b, e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        opcode = 4'($urandom); ra = W'($urandom); rb = W'($urandom);
        e.acc_cyc = cyc;
        sb_q.push_back(e);
    endtask

    // Consumer back-pressure: optional forced stall, otherwise random or always-ready.
    always @(posedge clk) begin
        #2;
        if (hold_cycles > 0 && out_valid) begin
            out_ready = 1'b0;
            hold_cycles--;
        end else begin
            out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    exp_t        cur;
    bit          presented = 1'b0;
    logic [W-1:0] held_out;
    logic [3:0]  held_fl;
    logic [3:0]  held_q;

    // Monitor: compare on first presentation, then check stability while stalled.
    always @(negedge clk) begin
        if (!rst_n) begin
            presented = 1'b0;
        end else begin
            if (sb_q.size() > 0 || out_valid) check("in_ready_low", in_ready, 0);
            if (out_valid) begin
                if (!presented) begin
                    if (sb_q.size() == 0) begin
                        check("unexpected_output", 1, 0);
                    end else begin
                        cur = sb_q.pop_front();
                        check("out", out, cur.res);
                        check("flags", flags, cur.fl);
                        check("write_rD", write_rd, cur.wrd);
                        check("write_pc", write_pc, cur.wpc);
                        check("memory_mode", memory_mode, cur.mem);
                        check("latency", cyc - cur.acc_cyc + 1, cur.lat);
                    end
                    held_out = out; held_fl = flags;
                    held_q = {write_rd, write_pc, memory_mode};
                    presented = 1'b1;
                end else begin
                    check("hold_out", out, held_out);
                    check("hold_flags", flags, held_fl);
                    check("hold_qual", {write_rd, write_pc, memory_mode}, held_q);
                end
                if (out_ready) presented = 1'b0;
            end
        end
    end

    initial begin
        int t;
        rst_n = 1'b0; in_valid = 1'b0; opcode = 4'h0; opcode_mode = 1'b0;
        immediate = '0; pc = '0; ra = '0; rb = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out", out, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_flags", flags, 0);
        check("rst_write", {write_rd, write_pc}, 0);
        check("rst_mem", memory_mode, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", in_ready, 1);

        issue(4'h0, 1'b0, 0, 0, 'h7FFF, 'h0001);
        issue(4'h1, 1'b0, 0, 0, 'h0005, 'h0005);
        issue(4'h9, 1'b1, 0, 0, 'h0003, 'hFFFF);
        issue(4'h9, 1'b0, 0, 0, 'h0003, 'hFFFF);
        issue(4'hA, 1'b0, 0, 0, 'h0001, 'h0004);
        hold_cycles = 3;
        issue(4'hE, 1'b0, 0, 0, 'h00FF, 'h0101);
        issue(4'hD, 1'b0, 'hFE, 'h0100, 'h1234, 'h1234);
        issue(4'hD, 1'b0, 'hFE, 'h0100, 'h1234, 'h1235);
        issue(4'hA, 1'b0, 0, 0, 'hBEEF, 'h0010);
        issue(4'hB, 1'b0, 0, 0, 'h8000, 'h000F);
        issue(4'hB, 1'b1, 0, 0, 'h8000, 'h000F);
        issue(4'h8, 1'b0, 'hA5, 0, 0, 0);
        issue(4'h8, 1'b1, 'hA5, 0, 0, 0);
        issue(4'hC, 1'b1, 'hFF, 'hFFF0, 0, 0);
        issue(4'hF, 1'b0, 0, 0, 'h1111, 'h2222);
        issue(4'h7, 1'b0, 0, 0, 'h5A5A, 'h0000);

        // Abort an in-flight multiply with reset.
        issue(4'hE, 1'b0, 0, 0, 'h1234, 'h5678);
        repeat (7) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", out_valid, 0);
        check("abort_flags", flags, 0);
        sb_q.delete();
        mflags = 4'b0000;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        issue(4'h0, 1'b0, 0, 0, 'h0002, 'h0003);

        rnd_ready = 1'b1;
        for (int i = 0; i < 200; i++) begin
            issue(4'($urandom), 1'($urandom), longint'($urandom_range(0, 255)),
                  longint'($urandom_range(0, 65535)), longint'($urandom_range(0, 65535)),
                  longint'($urandom_range(0, 65535)));
        end

        t = 0;
        while ((sb_q.size() > 0 || out_valid) && t < 500) begin
            @(negedge clk);
            t++;
        end
        check("drain", sb_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
